bitstream_loader: RTL and testbench

- Host-side transmitter for the patch-block configuration port.
- Accepts a load command and parallel configuration words over valid/ready handshakes.
- Serializes the words LSB-first onto the single serial bitstream line shared by the SMU and SRU.
- Drives the matching smuStreamValid or sruStreamValid strobe, so the SMU match tables or SRU PLA/control configuration can be loaded from a word-oriented bus or boot ROM.

---
 rtl/bitstream_loader_if.sv | 32 +++
 rtl/bitstream_loader.sv | 141 ++++++++++++++
 tb/tb_bitstream_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitstream_loader_if.sv
// Host-side bundle for the bitstream loader: command and word handshakes plus the
// serial configuration stream shared by the SMU and SRU.
interface bitstream_loader_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 16
);
    logic              cmdValid;
    logic              cmdReady;
    logic              cmdTarget;
    logic [LEN_W-1:0]  cmdNumSegments;
    logic              wordValid;
    logic              wordReady;
    logic [WORD_W-1:0] wordData;
    logic              bitstreamSerialOut;
    logic              smuStreamValid;
    logic              sruStreamValid;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output cmdValid, cmdTarget, cmdNumSegments, wordValid, wordData,
        input  cmdReady, wordReady, bitstreamSerialOut, smuStreamValid, sruStreamValid,
        input  busy, done, error
    );

    modport slave (
        input  cmdValid, cmdTarget, cmdNumSegments, wordValid, wordData,
        output cmdReady, wordReady, bitstreamSerialOut, smuStreamValid, sruStreamValid,
        output busy, done, error
    );
endinterface

// File: rtl/bitstream_loader.sv
// Serializes configuration words LSB-first onto the shared SMU/SRU bitstream line,
// strobing the valid of the target selected by the accepted command.
module bitstream_loader #(
    parameter int unsigned WORD_W           = 32,
    parameter int unsigned LEN_W            = 16,
    parameter int unsigned SMU_SEGMENT_SIZE = 64,
    parameter int unsigned SRU_SEGMENT_SIZE = 8
) (
    input logic               clk,
    input logic               rst,
    bitstream_loader_if.slave bus
);
    localparam int unsigned BitsW    = LEN_W + 7;
    localparam int unsigned WordCntW = $clog2(WORD_W + 1);
    localparam int unsigned SmuShift = $clog2(SMU_SEGMENT_SIZE);
    localparam int unsigned SruShift = $clog2(SRU_SEGMENT_SIZE);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} stateT;

    stateT               stateQ, stateD;
    logic                targetQ, targetD;
    logic [BitsW-1:0]    bitsLeftQ, bitsLeftD;
    logic [WordCntW-1:0] wordBitsLeftQ, wordBitsLeftD;
    logic [WORD_W-1:0]   shiftRegQ, shiftRegD;
    logic                serialQ, serialD;
    logic                smuValidQ, smuValidD;
    logic                sruValidQ, sruValidD;
    logic                doneQ, doneD;
    logic                errorQ, errorD;
    logic                cmdReadyC, wordReadyC;
    logic [BitsW-1:0]    segBitsSmu, segBitsSru;
    logic                lastBit, wordEnd;

    // Segment sizes are powers of two, so the total bit count is a plain shift.
    assign segBitsSmu = BitsW'(bus.cmdNumSegments) << SmuShift;
    assign segBitsSru = BitsW'(bus.cmdNumSegments) << SruShift;
    assign lastBit    = (bitsLeftQ == BitsW'(1));
    assign wordEnd    = (wordBitsLeftQ == WordCntW'(1));

    always_comb begin
        stateD        = stateQ;
        targetD       = targetQ;
        bitsLeftD     = bitsLeftQ;
        wordBitsLeftD = wordBitsLeftQ;
        shiftRegD     = shiftRegQ;
        serialD       = 1'b0;
        smuValidD     = 1'b0;
        sruValidD     = 1'b0;
        doneD         = 1'b0;
        errorD        = 1'b0;
        cmdReadyC     = 1'b0;
        wordReadyC    = 1'b0;

        unique case (stateQ)
            StIdle: begin
                cmdReadyC = 1'b1;
                if (bus.cmdValid) begin
                    if (bus.cmdNumSegments == '0) begin
                        errorD = 1'b1;
                    end else begin
                        targetD   = bus.cmdTarget;
                        bitsLeftD = bus.cmdTarget ? segBitsSru : segBitsSmu;
                        stateD    = StLoad;
                    end
                end
            end

            StLoad: begin
                wordReadyC = 1'b1;
                if (bus.wordValid) begin
                    shiftRegD     = bus.wordData;
                    wordBitsLeftD = WordCntW'(WORD_W);
                    stateD        = StShift;
                end
            end

            StShift: begin
                serialD       = shiftRegQ[0];
                smuValidD     = ~targetQ;
                sruValidD     = targetQ;
                shiftRegD     = shiftRegQ >> 1;
                bitsLeftD     = bitsLeftQ - BitsW'(1);
                wordBitsLeftD = wordBitsLeftQ - WordCntW'(1);
                if (lastBit) begin
                    // Leftover bits of the current word are dropped here.
                    stateD = StDone;
                end else if (wordEnd) begin
                    wordReadyC = 1'b1;
                    if (bus.wordValid) begin
                        shiftRegD     = bus.wordData;
                        wordBitsLeftD = WordCntW'(WORD_W);
                    end else begin
                        stateD = StLoad;
                    end
                end
            end

            StDone: begin
                doneD  = 1'b1;
                stateD = StIdle;
            end

            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ        <= StIdle;
            targetQ       <= 1'b0;
            bitsLeftQ     <= '0;
            wordBitsLeftQ <= '0;
            shiftRegQ     <= '0;
            serialQ       <= 1'b0;
            smuValidQ     <= 1'b0;
            sruValidQ     <= 1'b0;
            doneQ         <= 1'b0;
            errorQ        <= 1'b0;
        end else begin
            stateQ        <= stateD;
            targetQ       <= targetD;
            bitsLeftQ     <= bitsLeftD;
            wordBitsLeftQ <= wordBitsLeftD;
            shiftRegQ     <= shiftRegD;
            serialQ       <= serialD;
            smuValidQ     <= smuValidD;
            sruValidQ     <= sruValidD;
            doneQ         <= doneD;
            errorQ        <= errorD;
        end
    end

    assign bus.cmdReady           = cmdReadyC;
    assign bus.wordReady          = wordReadyC;
    assign bus.bitstreamSerialOut = serialQ;
    assign bus.smuStreamValid     = smuValidQ;
    assign bus.sruStreamValid     = sruValidQ;
    assign bus.busy               = (stateQ == StLoad) || (stateQ == StShift);
    assign bus.done               = doneQ;
    assign bus.error              = errorQ;
endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader: expected bits are queued when words are handed
// over and matched against the serial stream the monitor captures.
module tb_bitstream_loader;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;

    typedef struct { int cyc; logic tgt; logic b; } obsT;
    typedef struct { logic tgt; logic b; } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    obsT obsLog[$];
    expT expQ[$];
    int  doneLog[$];
    int  errLog[$];
    int  wrCnt = 0, busyCnt = 0, notRdyCnt = 0, smuCnt = 0, quietViol = 0, bothViol = 0;
    int  sbLeft = 0;
    logic sbTgt = 1'b0;

    bitstream_loader_if #(.WORD_W(WORD_W), .LEN_W(LEN_W)) bus ();

    bitstream_loader #(
        .WORD_W(WORD_W), .LEN_W(LEN_W), .SMU_SEGMENT_SIZE(64), .SRU_SEGMENT_SIZE(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture everything the DUT drives; comparisons happen in the directed sequence.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.smuStreamValid || bus.sruStreamValid)
                obsLog.push_back('{cyc, bus.sruStreamValid, bus.bitstreamSerialOut});
            else if (bus.bitstreamSerialOut !== 1'b0)
                quietViol <= quietViol + 1;
            if (bus.smuStreamValid && bus.sruStreamValid) bothViol <= bothViol + 1;
            if (bus.smuStreamValid) smuCnt <= smuCnt + 1;
            if (bus.done) doneLog.push_back(cyc);
            if (bus.error) errLog.push_back(cyc);
            if (bus.wordReady) wrCnt <= wrCnt + 1;
            if (bus.busy) busyCnt <= busyCnt + 1;
            if (!bus.cmdReady) notRdyCnt <= notRdyCnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issueCmd(input logic tgt, input logic [LEN_W-1:0] n, output int acc);
        bit ok = 0;
        bus.cmdValid = 1'b1;
        bus.cmdTarget = tgt;
        bus.cmdNumSegments = n;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmdReady === 1'b1) ok = 1;
            tick();
        end
        bus.cmdValid = 1'b0;
        acc = cyc;
        check("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic sendWord(input logic [WORD_W-1:0] data, input int delay, output int hs);
        bit ok = 0;
        repeat (delay) tick();
        bus.wordValid = 1'b1;
        bus.wordData = data;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.wordReady === 1'b1) ok = 1;
            tick();
        end
        bus.wordValid = 1'b0;
        hs = cyc;
        check("word_accept", 32'(ok), 32'd1);
        for (int i = 0; i < int'(WORD_W) && sbLeft > 0; i++) begin
            expQ.push_back('{sbTgt, data[i]});
            sbLeft--;
        end
    endtask

    task automatic waitDone(input int d0);
        for (int i = 0; i < 400 && doneLog.size() == d0; i++) tick();
        check("done_seen", 32'(doneLog.size() > d0), 32'd1);
        repeat (2) tick();
    endtask

    task automatic verifyRun(input string tag, input int startIdx, input int expCount,
                             input bit partial);
        obsT o;
        expT e;
        if (!partial) check({tag, "_count"}, 32'(obsLog.size() - startIdx), 32'(expCount));
        for (int i = startIdx; i < obsLog.size(); i++) begin
            o = obsLog[i];
            check($sformatf("%s_sb_nonempty%0d", tag, i - startIdx),
                  32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check($sformatf("%s_bit%0d", tag, i - startIdx),
                      32'({o.tgt, o.b}), 32'({e.tgt, e.b}));
            end
        end
        if (partial) expQ.delete();
        else check({tag, "_sb_left"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int n0, d0, e0, w0, b0, r0, s0, acc, hs1, hs2, last;
        bus.cmdValid = 1'b0;
        bus.cmdTarget = 1'b0;
        bus.cmdNumSegments = '0;
        bus.wordValid = 1'b0;
        bus.wordData = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmdReady", 32'(bus.cmdReady), 32'd1);
        check("rst_wordReady", 32'(bus.wordReady), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valids", 32'({bus.smuStreamValid, bus.sruStreamValid}), 32'd0);
        check("rst_serial", 32'(bus.bitstreamSerialOut), 32'd0);
        check("rst_done_err", 32'({bus.done, bus.error}), 32'd0);
        tick();

        // 1: SRU, one segment, single word 0xA5
        n0 = obsLog.size(); d0 = doneLog.size(); w0 = wrCnt; s0 = smuCnt;
        sbLeft = 8; sbTgt = 1'b1;
        issueCmd(1'b1, 16'd1, acc);
        sendWord(32'h0000_00A5, 0, hs1);
        waitDone(d0);
        verifyRun("t1", n0, 8, 0);
        last = obsLog[obsLog.size() - 1].cyc;
        check("t1_first_cycle", 32'(obsLog[n0].cyc), 32'(hs1 + 1));
        check("t1_span", 32'(last - obsLog[n0].cyc), 32'd7);
        check("t1_done_cycle", 32'(doneLog[d0]), 32'(last + 1));
        check("t1_done_pulses", 32'(doneLog.size() - d0), 32'd1);
        check("t1_wordReady_cycles", 32'(wrCnt - w0), 32'd1);
        check("t1_smu_silent", 32'(smuCnt - s0), 32'd0);

        // 2: SMU, one segment, back-to-back words
        n0 = obsLog.size(); d0 = doneLog.size(); w0 = wrCnt;
        sbLeft = 64; sbTgt = 1'b0;
        issueCmd(1'b0, 16'd1, acc);
        sendWord(32'h89AB_CDEF, 0, hs1);
        sendWord(32'h0123_4567, 0, hs2);
        waitDone(d0);
        verifyRun("t2", n0, 64, 0);
        last = obsLog[obsLog.size() - 1].cyc;
        check("t2_span", 32'(last - obsLog[n0].cyc), 32'd63);
        check("t2_word2_hs", 32'(hs2), 32'(hs1 + 32));
        check("t2_bit32_cycle", 32'(obsLog[n0 + 32].cyc), 32'(hs1 + 33));
        check("t2_bit32_value", 32'(obsLog[n0 + 32].b), 32'd1);
        check("t2_wordReady_cycles", 32'(wrCnt - w0), 32'd2);
        check("t2_done_cycle", 32'(doneLog[d0]), 32'(last + 1));

        // 3: second word three cycles late
        n0 = obsLog.size(); d0 = doneLog.size(); w0 = wrCnt;
        sbLeft = 64; sbTgt = 1'b0;
        issueCmd(1'b0, 16'd1, acc);
        sendWord(32'h89AB_CDEF, 0, hs1);
        sendWord(32'h0123_4567, 34, hs2);
        waitDone(d0);
        verifyRun("t3", n0, 64, 0);
        last = obsLog[obsLog.size() - 1].cyc;
        check("t3_gap", 32'(obsLog[n0 + 32].cyc - obsLog[n0 + 31].cyc), 32'd4);
        check("t3_span", 32'(last - obsLog[n0].cyc), 32'd66);
        check("t3_wordReady_cycles", 32'(wrCnt - w0), 32'd5);
        check("t3_done_cycle", 32'(doneLog[d0]), 32'(last + 1));

        // 4: zero-length command, with a stray word offered
        n0 = obsLog.size(); e0 = errLog.size(); w0 = wrCnt; b0 = busyCnt; r0 = notRdyCnt;
        bus.wordValid = 1'b1;
        issueCmd(1'b0, 16'd0, acc);
        repeat (4) tick();
        bus.wordValid = 1'b0;
        check("t4_err_pulses", 32'(errLog.size() - e0), 32'd1);
        check("t4_err_cycle", 32'(errLog[e0]), 32'(acc));
        check("t4_no_valid", 32'(obsLog.size() - n0), 32'd0);
        check("t4_no_wordReady", 32'(wrCnt - w0), 32'd0);
        check("t4_no_busy", 32'(busyCnt - b0), 32'd0);
        check("t4_cmdReady_held", 32'(notRdyCnt - r0), 32'd0);

        // 5: reset after ten SMU bits, then a clean SRU two-segment load
        n0 = obsLog.size();
        sbLeft = 64; sbTgt = 1'b0;
        issueCmd(1'b0, 16'd1, acc);
        sendWord(32'h5A5A_5A5A, 0, hs1);
        for (int i = 0; i < 100 && obsLog.size() - n0 < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_valids", 32'({bus.smuStreamValid, bus.sruStreamValid}), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_done", 32'(bus.done), 32'd0);
        check("t5_cmdReady", 32'(bus.cmdReady), 32'd1);
        check("t5_partial_count", 32'(obsLog.size() - n0 >= 10), 32'd1);
        verifyRun("t5a", n0, 0, 1);
        sbLeft = 0;
        tick();
        n0 = obsLog.size(); d0 = doneLog.size();
        sbLeft = 16; sbTgt = 1'b1;
        issueCmd(1'b1, 16'd2, acc);
        sendWord(32'h0000_C3E1, 0, hs1);
        waitDone(d0);
        verifyRun("t5b", n0, 16, 0);

        // 6: command offered mid-transfer must be dropped
        n0 = obsLog.size(); d0 = doneLog.size(); s0 = smuCnt;
        sbLeft = 16; sbTgt = 1'b1;
        issueCmd(1'b1, 16'd2, acc);
        sendWord(32'h0000_3C96, 0, hs1);
        repeat (3) tick();
        bus.cmdValid = 1'b1;
        bus.cmdTarget = 1'b0;
        bus.cmdNumSegments = 16'd5;
        @(negedge clk);
        check("t6_cmdReady_low", 32'(bus.cmdReady), 32'd0);
        tick();
        bus.cmdValid = 1'b0;
        waitDone(d0);
        verifyRun("t6", n0, 16, 0);
        b0 = busyCnt;
        n0 = obsLog.size();
        repeat (6) tick();
        check("t6_no_restart_busy", 32'(busyCnt - b0), 32'd0);
        check("t6_no_restart_bits", 32'(obsLog.size() - n0), 32'd0);
        check("t6_smu_silent", 32'(smuCnt - s0), 32'd0);

        check("quiet_serial_zero", 32'(quietViol), 32'd0);
        check("one_valid_at_most", 32'(bothViol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
